reg_bank_fwd_ctrl: RTL

- Forwarding and hazard controller for the register bank operand muxes.
- Tracks destination registers of the three instructions in flight ahead of decode: EX, DM and WB stages.
- Drives registered mux_sel_A / mux_sel_B / imm_sel so the EX-stage operands A and B pick the youngest in-flight result.
- Detects load-use hazards and stalls decode for one cycle, injecting a bubble into EX.

---
 rtl/reg_bank_fwd_ctrl_pkg.sv | 27 ++
 rtl/reg_bank_fwd_ctrl_fwd_match.sv | 34 +++
 rtl/reg_bank_fwd_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/reg_bank_fwd_ctrl_pkg.sv
// Shared types for the register bank forwarding controller: select encodings,
// address width and the per-stage scoreboard entry.
package reg_bank_fwd_ctrl_pkg;

  localparam int ADDR_W = 5;
  localparam int SEL_W  = 2;

  localparam logic [SEL_W-1:0] SEL_BANK = 2'b00;
  localparam logic [SEL_W-1:0] SEL_EX   = 2'b01;
  localparam logic [SEL_W-1:0] SEL_DM   = 2'b10;
  localparam logic [SEL_W-1:0] SEL_WB   = 2'b11;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic              load;
    logic [ADDR_W-1:0] rw;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

  // True when the entry will deliver a result for register addr.
  function automatic logic produces(input stage_t s, input logic [ADDR_W-1:0] addr);
    return s.valid & s.we & (s.rw == addr);
  endfunction

endpackage

// File: rtl/reg_bank_fwd_ctrl_fwd_match.sv
// Priority match of one source operand against the EX/DM/WB entries; purely combinational.
// Youngest producer wins; also flags a hit on a load still sitting in EX.
module fwd_match
  import reg_bank_fwd_ctrl_pkg::*;
(
  input  logic [ADDR_W-1:0] src,
  input  logic              use_src,
  input  stage_t            ex,
  input  stage_t            dm,
  input  stage_t            wb,
  output logic [SEL_W-1:0]  sel,
  output logic              ex_load_hit
);

  logic unused_load;
  assign unused_load = dm.load ^ wb.load;

  always_comb begin
    sel = SEL_BANK;
    if (use_src) begin
      if (produces(ex, src)) begin
        sel = SEL_EX;
      end else if (produces(dm, src)) begin
        sel = SEL_DM;
      end else if (produces(wb, src)) begin
        sel = SEL_WB;
      end
    end
  end

  // A load's data only exists at the DM output, so an EX hit on it cannot be forwarded.
  assign ex_load_hit = use_src & produces(ex, src) & ex.load;

endmodule

// File: rtl/reg_bank_fwd_ctrl.sv
// Forwarding/hazard controller: operand selects registered into EX one cycle after decode.
// stall is combinational and holds decode for exactly one bubble on a load-use hazard.
module reg_bank_fwd_ctrl
  import reg_bank_fwd_ctrl_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_RA,
  input  logic [ADDR_W-1:0] id_RB,
  input  logic              id_use_A,
  input  logic              id_use_B,
  input  logic              id_imm,
  input  logic [ADDR_W-1:0] id_RW,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              flush,
  output logic [SEL_W-1:0]  mux_sel_A,
  output logic [SEL_W-1:0]  mux_sel_B,
  output logic              imm_sel,
  output logic              stall,
  output logic [ADDR_W-1:0] ex_RW,
  output logic [ADDR_W-1:0] dm_RW,
  output logic [ADDR_W-1:0] wb_RW,
  output logic              ex_we,
  output logic              dm_we,
  output logic              wb_we
);

  stage_t           ex_q;
  stage_t           dm_q;
  stage_t           wb_q;
  stage_t           id_entry;
  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic             load_hit_a;
  logic             load_hit_b;
  logic             use_b_reg;
  logic             issue;

  // With an immediate the B port never reads the bank, so RB cannot hazard.
  assign use_b_reg = id_use_B & ~id_imm;

  fwd_match u_match_a (
    .src         (id_RA),
    .use_src     (id_use_A),
    .ex          (ex_q),
    .dm          (dm_q),
    .wb          (wb_q),
    .sel         (sel_a),
    .ex_load_hit (load_hit_a)
  );

  fwd_match u_match_b (
    .src         (id_RB),
    .use_src     (use_b_reg),
    .ex          (ex_q),
    .dm          (dm_q),
    .wb          (wb_q),
    .sel         (sel_b),
    .ex_load_hit (load_hit_b)
  );

  // flush redirects fetch, so a pending load-use on the killed instruction is moot.
  assign stall = ~rst & ~flush & id_valid & (load_hit_a | load_hit_b);
  assign issue = id_valid & ~stall & ~flush;

  always_comb begin
    id_entry       = STAGE_BUBBLE;
    id_entry.valid = 1'b1;
    id_entry.we    = id_we;
    id_entry.load  = id_load;
    id_entry.rw    = id_RW;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= STAGE_BUBBLE;
      dm_q      <= STAGE_BUBBLE;
      wb_q      <= STAGE_BUBBLE;
      mux_sel_A <= SEL_BANK;
      mux_sel_B <= SEL_BANK;
      imm_sel   <= 1'b0;
    end else begin
      ex_q      <= issue ? id_entry : STAGE_BUBBLE;
      dm_q      <= ex_q;
      wb_q      <= dm_q;
      mux_sel_A <= issue ? sel_a : SEL_BANK;
      mux_sel_B <= issue ? sel_b : SEL_BANK;
      imm_sel   <= issue & id_imm;
    end
  end

  assign ex_RW = ex_q.rw;
  assign dm_RW = dm_q.rw;
  assign wb_RW = wb_q.rw;
  assign ex_we = ex_q.we;
  assign dm_we = dm_q.we;
  assign wb_we = wb_q.we;

  logic unused_load;
  assign unused_load = wb_q.load ^ wb_q.valid;

endmodule
